// File: rtl/vend_coin_arbiter_if.sv
// Coin-side and core-side signals of the vending coin arbiter.
// The arbiter connects through the slave modport; the environment that
// offers coins and models the vending core uses the master modport.
interface vend_coin_arbiter_if #(
  parameter int CW = 8
);
  logic [1:0]    coin_valid;
  logic [3:0]    coin_code;
  logic [1:0]    coin_ready;
  logic [1:0]    core_in;
  logic          core_rst;
  logic          core_out;
  logic [1:0]    core_change;
  logic [1:0]    vend_done;
  logic [1:0]    vend_change;
  logic [1:0]    refund;
  logic [2:0]    refund_amt;
  logic [1:0]    reject;
  logic          busy;
  logic          owner;
  logic [CW-1:0] vend_count;

  modport slave (
    input  coin_valid, coin_code, core_out, core_change,
    output coin_ready, core_in, core_rst, vend_done, vend_change,
           refund, refund_amt, reject, busy, owner, vend_count
  );

  modport master (
    output coin_valid, coin_code, core_out, core_change,
    input  coin_ready, core_in, core_rst, vend_done, vend_change,
           refund, refund_amt, reject, busy, owner, vend_count
  );
endinterface

// File: rtl/vend_coin_arbiter.sv
// Round-robin front end that shares one vending core between two coin
// requesters. A transaction stays locked to its owner until the core vends
// or the owner stays silent for TIMEOUT cycles, in which case the core is
// reset and the accumulated credit is refunded.
module vend_coin_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5,
  parameter int CW      = 8
) (
  input logic                clk,
  input logic                rst,
  vend_coin_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_ISSUE,
    S_WAIT,
    S_ABORT
  } state_t;

  // Credit value of a coin code in 5c units; only 01 and 10 carry value.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   return 2'd1;
      2'b10:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Credit accumulation clamps at the top of the 3-bit range.
  function automatic logic [2:0] sat_credit(input logic [2:0] c, input logic [1:0] v);
    logic [3:0] s;
    s = {1'b0, c} + {2'b00, v};
    return s[3] ? 3'b111 : s[2:0];
  endfunction

  // Vend counter sticks at all-ones.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          rr_ptr, rr_nxt;
  logic          owner_q, owner_nxt;
  logic [1:0]    coin_q, coin_nxt;
  logic [2:0]    credit, credit_nxt;
  logic [1:0]    core_in_q, core_in_nxt;
  logic          core_rst_q;

  logic [1:0]    vend_done_q, vend_done_nxt;
  logic [1:0]    vend_chg_q, vend_chg_nxt;
  logic [1:0]    refund_q, refund_nxt;
  logic [2:0]    refund_amt_q, refund_amt_nxt;
  logic [1:0]    reject_q, reject_nxt;
  logic [CW-1:0] vcount;
  logic          vend_inc;

  logic [1:0]    code0, code1;
  logic [1:0]    elig;
  logic [1:0]    ready;
  logic          grant;
  logic [1:0]    gcode;
  logic          hs;

  assign code0   = bus.coin_code[1:0];
  assign code1   = bus.coin_code[3:2];
  // A requester competes only while offering a non-empty code.
  assign elig[0] = bus.coin_valid[0] && (code0 != 2'b00);
  assign elig[1] = bus.coin_valid[1] && (code1 != 2'b00);

  // Arbitration, handshake and next-state decode
  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    rr_nxt         = rr_ptr;
    owner_nxt      = owner_q;
    coin_nxt       = coin_q;
    credit_nxt     = credit;
    core_in_nxt    = 2'b00;
    vend_done_nxt  = 2'b00;
    vend_chg_nxt   = 2'b00;
    refund_nxt     = 2'b00;
    refund_amt_nxt = 3'd0;
    reject_nxt     = 2'b00;
    vend_inc       = 1'b0;
    ready          = 2'b00;
    grant          = owner_q;
    gcode          = 2'b00;
    hs             = 1'b0;

    case (state)
      S_IDLE: begin
        // Contention goes to rr_ptr; a lone offer wins outright.
        if (elig == 2'b11) begin
          grant  = rr_ptr;
          rr_nxt = ~rr_ptr;
        end else begin
          grant = elig[1];
        end
        hs    = |elig;
        gcode = grant ? code1 : code0;
        if (hs) begin
          ready = grant ? 2'b10 : 2'b01;
          if (gcode == 2'b11) begin
            reject_nxt = ready;
          end else begin
            owner_nxt   = grant;
            coin_nxt    = gcode;
            core_in_nxt = gcode;
            state_nxt   = S_ISSUE;
          end
        end
      end

      S_HOLD: begin
        // Only the owner may add coins; a handshake beats the timeout.
        grant = owner_q;
        gcode = owner_q ? code1 : code0;
        hs    = elig[owner_q];
        if (hs) begin
          ready     = owner_q ? 2'b10 : 2'b01;
          timer_nxt = '0;
          if (gcode == 2'b11) begin
            reject_nxt = ready;
          end else begin
            coin_nxt    = gcode;
            core_in_nxt = gcode;
            state_nxt   = S_ISSUE;
          end
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timer_nxt      = '0;
          refund_nxt     = owner_q ? 2'b10 : 2'b01;
          refund_amt_nxt = credit;
          state_nxt      = S_ABORT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      S_ISSUE: begin
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        // The core's registered response to the issued coin is visible now.
        if (bus.core_out) begin
          vend_done_nxt = owner_q ? 2'b10 : 2'b01;
          vend_chg_nxt  = bus.core_change;
          vend_inc      = 1'b1;
          credit_nxt    = 3'd0;
          state_nxt     = S_IDLE;
        end else begin
          credit_nxt = sat_credit(credit, coin_value(coin_q));
          timer_nxt  = '0;
          state_nxt  = S_HOLD;
        end
      end

      S_ABORT: begin
        credit_nxt = 3'd0;
        state_nxt  = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Transaction control: FSM state, timeout timer, pointer, owner, credit, core drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      rr_ptr     <= 1'b0;
      owner_q    <= 1'b0;
      coin_q     <= 2'b00;
      credit     <= 3'd0;
      core_in_q  <= 2'b00;
      core_rst_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      rr_ptr     <= rr_nxt;
      owner_q    <= owner_nxt;
      coin_q     <= coin_nxt;
      credit     <= credit_nxt;
      core_in_q  <= core_in_nxt;
      core_rst_q <= (state_nxt == S_ABORT);
    end
  end

  // Registered result pulses and the vend counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vend_done_q  <= 2'b00;
      vend_chg_q   <= 2'b00;
      refund_q     <= 2'b00;
      refund_amt_q <= 3'd0;
      reject_q     <= 2'b00;
      vcount       <= '0;
    end else begin
      vend_done_q  <= vend_done_nxt;
      vend_chg_q   <= vend_chg_nxt;
      refund_q     <= refund_nxt;
      refund_amt_q <= refund_amt_nxt;
      reject_q     <= reject_nxt;
      if (vend_inc) begin
        vcount <= sat_inc(vcount);
      end
    end
  end

  assign bus.coin_ready  = ready;
  assign bus.core_in     = core_in_q;
  assign bus.core_rst    = core_rst_q;
  assign bus.vend_done   = vend_done_q;
  assign bus.vend_change = vend_chg_q;
  assign bus.refund      = refund_q;
  assign bus.refund_amt  = refund_amt_q;
  assign bus.reject      = reject_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.owner       = owner_q;
  assign bus.vend_count  = vcount;

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// Bench for vend_coin_arbiter: a transaction-level reference model predicts
// every output each cycle from coin arithmetic and a per-cycle event
// calendar; directed scenarios pin literal values; a random phase follows.
module tb_vend_coin_arbiter;
  localparam int TIMEOUT = 16;
  localparam int TW      = 5;
  localparam int CW      = 4;
  localparam int N       = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vend_coin_arbiter_if #(.CW(CW)) bus();

  vend_coin_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW), .CW(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Vending core stand-in: 15c item, registered out/change, sync reset.
  int core_tot = 0;
  always @(posedge clk) begin
    if (bus.core_rst) begin
      core_tot = 0;
      bus.core_out    <= 1'b0;
      bus.core_change <= 2'b00;
    end else if (bus.core_in == 2'b01 || bus.core_in == 2'b10) begin
      core_tot = core_tot + ((bus.core_in == 2'b01) ? 1 : 2);
      if (core_tot >= 3) begin
        bus.core_out    <= 1'b1;
        bus.core_change <= 2'(core_tot - 3);
        core_tot = 0;
      end else begin
        bus.core_out    <= 1'b0;
        bus.core_change <= 2'b00;
      end
    end else begin
      bus.core_out    <= 1'b0;
      bus.core_change <= 2'b00;
    end
  end

  // Reference model: event calendar indexed by cycle plus transaction state.
  bit [1:0] cal_cin [N];
  bit [1:0] cal_vd  [N];
  bit [1:0] cal_vch [N];
  bit [1:0] cal_rj  [N];
  bit       cal_vinc[N];

  int acc_from, hold_start, credit_m, vc_m, tot, ci, jj;
  bit txn_open, rr_m, own_m, crst_hold, abort_now, was_idle, g;
  bit [1:0] elig, e_rdy, e_rf, gcode;
  bit [2:0] e_ra;
  bit e_busy, e_crst;

  always @(negedge clk) begin
    ci = cyc % N;
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        jj = (cyc + k) % N;
        cal_cin[jj] = 0; cal_vd[jj] = 0; cal_vch[jj] = 0; cal_rj[jj] = 0; cal_vinc[jj] = 0;
      end
      acc_from = 0; hold_start = 0; credit_m = 0; vc_m = 0;
      txn_open = 0; rr_m = 0; own_m = 0; crst_hold = 1;
      check("rst_core_rst", bus.core_rst, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_core_in", bus.core_in, 0);
      check("rst_vend_done", bus.vend_done, 0);
      check("rst_refund", bus.refund, 0);
      check("rst_reject", bus.reject, 0);
      check("rst_owner", bus.owner, 0);
      check("rst_vend_count", bus.vend_count, 0);
    end else begin
      if (cal_vinc[ci]) vc_m = (vc_m == (1 << CW) - 1) ? vc_m : vc_m + 1;
      abort_now = txn_open && (cyc >= acc_from) && (cyc == hold_start + TIMEOUT);
      e_crst = crst_hold | abort_now;
      e_rf   = abort_now ? (own_m ? 2'b10 : 2'b01) : 2'b00;
      e_ra   = abort_now ? 3'(credit_m) : 3'd0;
      e_busy = (cyc < acc_from) || txn_open;
      elig[0] = bus.coin_valid[0] && (bus.coin_code[1:0] != 2'b00);
      elig[1] = bus.coin_valid[1] && (bus.coin_code[3:2] != 2'b00);
      e_rdy = 2'b00;
      g     = 1'b0;
      if (cyc >= acc_from && !abort_now) begin
        if (txn_open) begin
          g = own_m;
          e_rdy[g] = elig[g];
        end else if (elig == 2'b11) begin
          g = rr_m;
          e_rdy = g ? 2'b10 : 2'b01;
        end else begin
          g = elig[1];
          e_rdy = elig;
        end
      end

      check("coin_ready", bus.coin_ready, e_rdy);
      check("core_in", bus.core_in, cal_cin[ci]);
      check("core_rst", bus.core_rst, e_crst);
      check("busy", bus.busy, e_busy);
      check("owner", bus.owner, own_m);
      check("vend_done", bus.vend_done, cal_vd[ci]);
      check("vend_change", bus.vend_change, cal_vch[ci]);
      check("refund", bus.refund, e_rf);
      check("refund_amt", bus.refund_amt, e_ra);
      check("reject", bus.reject, cal_rj[ci]);
      check("vend_count", bus.vend_count, vc_m);

      if (abort_now) begin
        credit_m = 0;
        txn_open = 0;
      end
      if (e_rdy != 2'b00) begin
        was_idle = !txn_open;
        gcode = g ? bus.coin_code[3:2] : bus.coin_code[1:0];
        if (was_idle && elig == 2'b11) rr_m = ~g;
        if (gcode == 2'b11) begin
          cal_rj[(cyc + 1) % N] = g ? 2'b10 : 2'b01;
          if (!was_idle) hold_start = cyc + 1;
        end else begin
          own_m = g;
          cal_cin[(cyc + 1) % N] = gcode;
          acc_from = cyc + 3;
          tot = credit_m + ((gcode == 2'b01) ? 1 : 2);
          if (tot >= 3) begin
            cal_vd[(cyc + 3) % N]   = g ? 2'b10 : 2'b01;
            cal_vch[(cyc + 3) % N]  = 2'(tot - 3);
            cal_vinc[(cyc + 3) % N] = 1'b1;
            credit_m = 0;
            txn_open = 0;
          end else begin
            credit_m   = tot;
            txn_open   = 1;
            hold_start = cyc + 3;
          end
        end
      end
      crst_hold = 0;
      cal_cin[ci] = 0; cal_vd[ci] = 0; cal_vch[ci] = 0; cal_rj[ci] = 0; cal_vinc[ci] = 0;
    end
  end

  // Called at posedge+1; asserts reset immediately, releases it two edges later.
  task automatic do_reset();
    rst = 1'b0;
    bus.coin_valid = 2'b00;
    bus.coin_code  = 4'h0;
    #1;
    check("async_core_rst", bus.core_rst, 1);
    check("async_busy", bus.busy, 0);
    check("async_core_in", bus.core_in, 0);
    check("async_vend_done", bus.vend_done, 0);
    check("async_refund", bus.refund, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rel_core_rst_hold", bus.core_rst, 1);
    @(posedge clk); #1;
    check("rel_core_rst_fall", bus.core_rst, 0);
  endtask

  // Offers one coin and returns the handshake cycle; ends at posedge+1 after it.
  task automatic offer(input int req, input logic [1:0] code, output int t);
    logic [3:0] cc;
    cc = bus.coin_code;
    cc[2*req +: 2] = code;
    bus.coin_code = cc;
    bus.coin_valid[req] = 1'b1;
    t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      @(negedge clk);
      if (bus.coin_ready[req]) t = cyc;
    end
    if (t < 0) check("offer_handshake", bus.coin_ready[req], 1);
    @(posedge clk); #1;
    bus.coin_valid[req] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  int t1, t2;
  bit [1:0] v;
  bit [1:0] hs;
  logic [1:0] cd [2];
  int gap [2];
  int life [2];
  int r;

  initial begin
    bus.coin_valid = 2'b00;
    bus.coin_code  = 4'h0;
    #1;
    do_reset();

    // Two coins from req0 (10 then 01) make 15c: vend with no change.
    offer(0, 2'b10, t1);
    check("c1_core_in", bus.core_in, 2'b10);
    check("c1_busy", bus.busy, 1);
    @(posedge clk); #1;
    check("c1_core_in_clear", bus.core_in, 2'b00);
    offer(0, 2'b01, t2);
    check("c2_hold_latency", t2 - t1, 3);
    check("c2_core_in", bus.core_in, 2'b01);
    repeat (2) @(posedge clk); #1;
    check("c2_vend_done", bus.vend_done, 2'b01);
    check("c2_vend_change", bus.vend_change, 2'b00);
    check("c2_vend_count", bus.vend_count, 1);
    check("c2_busy", bus.busy, 0);
    @(posedge clk); #1;
    check("c2_vend_done_pulse", bus.vend_done, 2'b00);

    // Contention from reset: req0 first, req1 locked out, then req1 wins.
    @(posedge clk); #1;
    do_reset();
    bus.coin_code  = 4'b1010;
    bus.coin_valid = 2'b11;
    @(negedge clk);
    check("arb_first_grant", bus.coin_ready, 2'b01);
    t1 = cyc;
    @(posedge clk); #1;
    bus.coin_code = 4'b1001;
    t2 = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("arb_other_locked", bus.coin_ready[1], 0);
      if (bus.coin_ready[0]) begin
        t2 = cyc;
        break;
      end
    end
    check("arb_owner_regrant", t2 - t1, 3);
    @(posedge clk); #1;
    bus.coin_code = 4'b1010;
    repeat (2) @(posedge clk); #1;
    check("arb_vend_done", bus.vend_done, 2'b01);
    @(negedge clk);
    check("arb_rr_grant", bus.coin_ready, 2'b10);
    @(posedge clk); #1;
    bus.coin_valid = 2'b00;
    repeat (25) @(posedge clk);
    #1;

    // Timeout after a single 10 coin: abort refunds 2 units to req0.
    do_reset();
    offer(0, 2'b10, t1);
    repeat (18) @(posedge clk);
    #1;
    check("abort_core_rst", bus.core_rst, 1);
    check("abort_refund", bus.refund, 2'b01);
    check("abort_amt", bus.refund_amt, 3'd2);
    check("abort_busy", bus.busy, 1);
    @(posedge clk); #1;
    check("post_abort_busy", bus.busy, 0);
    check("post_abort_refund", bus.refund, 2'b00);
    check("post_abort_core_rst", bus.core_rst, 0);

    // Invalid coin from req1 in IDLE is rejected.
    @(posedge clk); #1;
    do_reset();
    bus.coin_code  = 4'b1100;
    bus.coin_valid = 2'b10;
    @(negedge clk);
    check("rej_ready", bus.coin_ready, 2'b10);
    @(posedge clk); #1;
    bus.coin_valid = 2'b00;
    check("rej_pulse", bus.reject, 2'b10);
    check("rej_core_in", bus.core_in, 2'b00);
    check("rej_busy", bus.busy, 0);
    @(posedge clk); #1;
    check("rej_pulse_end", bus.reject, 2'b00);

    // Reset during WAIT discards the transaction silently.
    do_reset();
    offer(0, 2'b10, t1);
    @(posedge clk); #1;
    check("wait_busy", bus.busy, 1);
    do_reset();
    repeat (6) @(posedge clk);
    #1;
    check("wr_no_refund", bus.refund, 2'b00);
    check("wr_idle", bus.busy, 0);

    // Randomized phase.
    do_reset();
    v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      cd[i] = 2'b00; gap[i] = 0; life[i] = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      hs = bus.coin_valid & bus.coin_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          if (hs[i]) begin
            v[i] = 1'b0;
            gap[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 26)) : int'($urandom_range(0, 4));
          end else if (cd[i] == 2'b00) begin
            life[i]--;
            if (life[i] <= 0) v[i] = 1'b0;
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else begin
          v[i] = 1'b1;
          r = int'($urandom_range(0, 15));
          cd[i] = (r < 7) ? 2'b01 : (r < 13) ? 2'b10 : (r < 15) ? 2'b11 : 2'b00;
          life[i] = int'($urandom_range(1, 4));
        end
      end
      bus.coin_code  = {cd[1], cd[0]};
      bus.coin_valid = v;
    end
    bus.coin_valid = 2'b00;
    repeat (40) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_coin_arbiter.md
Name: vend_coin_arbiter

Overview:
- Front-end controller for the single-channel vending core (`clk`, `rst`, `in[1:0]`, `out`, `change[1:0]`).
- Shares the core between two coin requesters using round-robin arbitration. Each transaction is locked to one owner until a vend occurs or the transaction times out.
- Serialises each accepted coin into a one-cycle core_in pulse and samples the core's registered out/change.
- On timeout, resets the core and reports a refund to the owner.

Parameters:
- TIMEOUT, 16, idle cycles allowed in HOLD before abort (must be >= 2).
- TW, 5, width of timeout counter (2^TW > TIMEOUT).
- CW, 8, width of vend_count (saturating).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coin_valid  in  2  per-requester coin offer; bit i belongs to requester i.
- coin_code  in  4  [2i+1:2i] = coin of requester i; 01=5c, 10=10c, 11=invalid, 00=ignored.
- coin_ready  out  2  per-requester accept; a handshake occurs when valid&ready are both high.
- core_in  out  2  drives the core's in[1:0].
- core_rst  out  1  drives the core's active-high synchronous reset.
- core_out  in  1  core's out.
- core_change  in  2  core's change; 00=none, 01=5c, 10=10c.
- vend_done  out  2  one-cycle pulse to the owner when the core vends.
- vend_change  out  2  change code; valid only while vend_done is high.
- refund  out  2  one-cycle pulse to the owner on abort.
- refund_amt  out  3  credit in 5c units; valid only while refund is high.
- reject  out  2  one-cycle pulse when an 11 coin is accepted and discarded.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  index of the current or last owner.
- vend_count  out  CW  total vends since reset; saturates at all-ones.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, core_in=00, core_rst=1, credit=0, timer=0, rr_ptr=0, owner=0, vend_count=0.
  - All pulses are 0.
  - core_rst is registered and falls on the first clk edge after rst rises.
  - Reset mid-transaction discards credit with no refund pulse.
- coin_ready is combinational from state, rr_ptr, owner and coin_valid, and is never high in ISSUE, WAIT or ABORT.
- IDLE:
  - If only one coin_valid bit is high with a non-00 code, that requester is granted.
  - If both are high, requester rr_ptr is granted and rr_ptr is set to ~grant.
  - At most one coin_ready bit is high.
  - Handshake with code 01/10: owner=grant, core_in is registered, next state is ISSUE.
  - Handshake with code 11: reject pulse next cycle, state stays IDLE.
  - A valid with code 00 is never readied.
- HOLD:
  - Only the owner can be readied; the other requester's coin_ready=0.
  - timer increments each cycle with no owner handshake.
  - Owner handshake (01/10): timer=0, next state is ISSUE. Code 11: reject pulse, timer=0, stay in HOLD.
  - timer==TIMEOUT-1 with no handshake: next state is ABORT.
  - A handshake takes priority over the timeout in the same cycle.
- ISSUE: core_in=coin for exactly one cycle; next state is WAIT.
- WAIT:
  - core_in=00.
  - At the end of WAIT, sample core_out and core_change.
  - If core_out=1: next cycle vend_done[owner]=1 and vend_change=core_change; vend_count+1 (saturating); credit=0; state=IDLE.
  - Else: credit += coin value (01->1, 10->2); timer=0; state=HOLD.
- ABORT (one cycle):
  - core_rst=1 in this cycle.
  - refund[owner]=1 and refund_amt=credit in this cycle.
  - credit=0; next state is IDLE.
- Latency: a handshake at cycle T puts the coin on core_in at T+1 and produces the vend_done/refund-path decision at T+3. There are at least 3 cycles between successive coins of one owner.
- Pulse outputs are registered. A requester may hold valid high across non-ready cycles; its code must be stable while valid is high.

Test Plan:
- Reset check: hold rst=0 -> core_rst=1, busy=0, core_in=00. Release rst -> core_rst=0 after one clk edge.
- Req0 inserts 10 then 01, with the core vending on the 15c total and returning change 00 -> core_in sequence is 10,00,...,01,00; vend_done=01 with vend_change=00 at T+3 of the second coin; vend_count=1.
- Both requesters assert 10 in IDLE from reset -> req0 is granted (rr_ptr=0). During HOLD, req1's coin_ready stays 0 until req0 vends. The next IDLE contention grants req1.
- Req0 inserts 10, then goes idle for 16 cycles -> ABORT: core_rst=1 for one cycle, refund=01, refund_amt=2, busy=0 the next cycle.
- Req1 offers 11 in IDLE -> reject=10 one cycle later, core_in stays 00, state remains IDLE.
- Assert rst=0 while in WAIT after a 10 coin -> all outputs return to reset values immediately, with no refund or vend pulse.
